// File: rtl/run_ctl_pkg.sv
// Shared opcodes, run-state encodings and default widths for the counter
// run-control sequencer.
package run_ctl_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned STEP_W_DEF = 16;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP      = 3'd0,
    OP_RUN      = 3'd1,
    OP_HALT     = 3'd2,
    OP_STEP     = 3'd3,
    OP_CLEAR    = 3'd4,
    OP_SET_BP   = 3'd5,
    OP_CLR_BP   = 3'd6,
    OP_SET_FAST = 3'd7
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_CLEARING = 2'd3
  } run_state_e;

endpackage

// File: rtl/run_ctl_bp_cmp.sv
// Breakpoint register and equality compare; the skip flag masks the match
// for the first cycle after (re)starting so a parked counter can move on.
module run_ctl_bp_cmp
  import run_ctl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_set_bp,
  input  logic             i_clr_bp,
  input  logic [WIDTH-1:0] i_bp_val,
  input  logic             i_enter_run,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_bp_match
);

  logic [WIDTH-1:0] r_bp;
  logic             r_bp_en;
  logic             r_skip;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_bp    <= '0;
      r_bp_en <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_skip <= i_enter_run;
      if (i_set_bp) begin
        r_bp    <= i_bp_val;
        r_bp_en <= 1'b1;
      end else if (i_clr_bp) begin
        r_bp_en <= 1'b0;
      end
    end
  end

  assign o_bp_match = r_bp_en && (i_count == r_bp) && !r_skip;

endmodule

// File: rtl/counter_run_controller.sv
// Run-control sequencer for the supervisor cycle counter: command decode,
// run/step/clear FSM and step counter, with breakpoint halting.
module counter_run_controller
  import run_ctl_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [WIDTH-1:0]   cmd_arg,
  input  logic [WIDTH-1:0]   count,
  output logic               ctr_reset,
  output logic               ctr_enable,
  output logic               ctr_step,
  output logic               ctr_fast,
  output logic [STATE_W-1:0] run_state,
  output logic               break_hit,
  output logic               cmd_err
);

  run_state_e        r_state;
  logic [STEP_W-1:0] r_steps_left;
  logic              r_fast;
  logic              r_break_hit;
  logic              r_cmd_err;

  op_e               w_op;
  logic              w_accept;
  logic              w_is_go;
  logic              w_is_halt;
  logic              w_enter_run;
  logic              w_bp_match;
  logic [STEP_W-1:0] w_step_arg;

  assign w_op        = op_e'(cmd_op);
  assign cmd_ready   = (r_state != ST_CLEARING);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_is_go     = w_accept && (w_op == OP_RUN || w_op == OP_STEP || w_op == OP_CLEAR);
  assign w_is_halt   = w_accept && (w_op == OP_HALT);
  assign w_enter_run = w_accept && (r_state == ST_HALTED) && (w_op == OP_RUN || w_op == OP_STEP);
  assign w_step_arg  = cmd_arg[STEP_W-1:0];

  run_ctl_bp_cmp #(.WIDTH(WIDTH)) u_bp_cmp (
    .CLK         (CLK),
    .reset       (reset),
    .i_set_bp    (w_accept && (w_op == OP_SET_BP)),
    .i_clr_bp    (w_accept && (w_op == OP_CLR_BP)),
    .i_bp_val    (cmd_arg),
    .i_enter_run (w_enter_run),
    .i_count     (count),
    .o_bp_match  (w_bp_match)
  );

  // Counter controls are combinational so the counter stops on bp, never bp+1
  assign ctr_reset  = reset || (r_state == ST_CLEARING);
  assign ctr_enable = (r_state == ST_RUNNING) && !w_bp_match;
  assign ctr_step   = (r_state == ST_STEPPING) && !w_bp_match;
  assign ctr_fast   = r_fast;
  assign run_state  = r_state;
  assign break_hit  = r_break_hit;
  assign cmd_err    = r_cmd_err;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= ST_HALTED;
      r_steps_left <= '0;
      r_fast       <= 1'b0;
      r_break_hit  <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_accept && (w_op == OP_SET_FAST)) r_fast <= cmd_arg[0];
      case (r_state)
        ST_HALTED: begin
          if (w_accept) begin
            case (w_op)
              OP_RUN: begin
                r_state     <= ST_RUNNING;
                r_break_hit <= 1'b0;
              end
              OP_STEP: begin
                r_state      <= ST_STEPPING;
                r_steps_left <= (w_step_arg == '0) ? STEP_W'(1) : w_step_arg;
                r_break_hit  <= 1'b0;
              end
              OP_CLEAR: begin
                r_state     <= ST_CLEARING;
                r_break_hit <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_RUNNING: begin
          if (w_is_go) r_cmd_err <= 1'b1;
          // Breakpoint wins over a simultaneous HALT so the flag is reported
          if (w_bp_match) begin
            r_state     <= ST_HALTED;
            r_break_hit <= 1'b1;
          end else if (w_is_halt) begin
            r_state <= ST_HALTED;
          end
        end
        ST_STEPPING: begin
          if (w_is_go) r_cmd_err <= 1'b1;
          if (w_bp_match) begin
            r_state      <= ST_HALTED;
            r_break_hit  <= 1'b1;
            r_steps_left <= '0;
          end else if (r_steps_left == STEP_W'(1) || w_is_halt) begin
            r_state      <= ST_HALTED;
            r_steps_left <= '0;
          end else begin
            r_steps_left <= r_steps_left - STEP_W'(1);
          end
        end
        ST_CLEARING: r_state <= ST_HALTED;
        default:     r_state <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with a behavioural cycle counter.
module tb_counter_run_controller;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] count;
  logic        ctr_reset, ctr_enable, ctr_step, ctr_fast;
  logic [1:0]  run_state;
  logic        break_hit, cmd_err;

  int n_pass  = 0;
  int n_total = 0;
  int en_cycles   = 0;
  int step_pulses = 0;

  always #5 CLK = ~CLK;

  counter_run_controller #(.WIDTH(32), .STEP_W(16)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .count      (count),
    .ctr_reset  (ctr_reset),
    .ctr_enable (ctr_enable),
    .ctr_step   (ctr_step),
    .ctr_fast   (ctr_fast),
    .run_state  (run_state),
    .break_hit  (break_hit),
    .cmd_err    (cmd_err)
  );

  // Free-running counter the controller supervises
  always @(posedge CLK) begin
    if (ctr_reset) count <= '0;
    else if (ctr_enable || ctr_step) count <= count + 32'd1;
    if (ctr_enable) en_cycles <= en_cycles + 1;
    if (ctr_step) step_pulses <= step_pulses + 1;
  end

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = '0;
  endtask

  task automatic wait_halted(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (run_state == 2'd0) break;
    end
    n_total++;
    if (i >= budget) $display("FAIL %s_timeout run_state=%0d never reached 0", tag, run_state);
    else n_pass++;
  endtask

  task automatic do_clear();
    send_cmd(3'd4, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_total++; if (run_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", run_state); else n_pass++;
    n_total++; if (ctr_reset !== 1'b1) $display("FAIL rst_ctr_reset got %b exp 1", ctr_reset); else n_pass++;
    n_total++; if ({ctr_enable, ctr_step, ctr_fast, break_hit, cmd_err} !== 5'b0)
      $display("FAIL rst_outputs got %b exp 00000", {ctr_enable, ctr_step, ctr_fast, break_hit, cmd_err}); else n_pass++;
    reset = 1'b0;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", cmd_ready); else n_pass++;
    n_total++; if (count !== 32'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_run_halt();
    int e0;
    e0 = en_cycles;
    send_cmd(3'd1, 32'd0);
    n_total++; if (run_state !== 2'd1) $display("FAIL run_state got %0d exp 1", run_state); else n_pass++;
    n_total++; if (count !== 32'd0 || ctr_enable !== 1'b1)
      $display("FAIL run_latency count=%0d en=%b exp 0/1", count, ctr_enable); else n_pass++;
    repeat (9) @(posedge CLK);
    send_cmd(3'd2, 32'd0);
    n_total++; if (run_state !== 2'd0) $display("FAIL halt_state got %0d exp 0", run_state); else n_pass++;
    n_total++; if (count !== 32'd10) $display("FAIL halt_count got %0d exp 10", count); else n_pass++;
    n_total++; if (en_cycles - e0 !== 10) $display("FAIL halt_en_cycles got %0d exp 10", en_cycles - e0); else n_pass++;
    n_total++; if (break_hit !== 1'b0) $display("FAIL halt_break got %b exp 0", break_hit); else n_pass++;
  endtask

  task automatic test_breakpoint();
    int i;
    do_clear();
    send_cmd(3'd5, 32'd100);
    send_cmd(3'd1, 32'd0);
    for (i = 0; i < 200; i++) begin
      if (count == 32'd100) break;
      @(posedge CLK);
      #1;
    end
    n_total++; if (ctr_enable !== 1'b0 || run_state !== 2'd1)
      $display("FAIL bp_at_match en=%b state=%0d exp 0/1 (count=%0d)", ctr_enable, run_state, count); else n_pass++;
    @(posedge CLK);
    #1;
    n_total++; if (run_state !== 2'd0 || break_hit !== 1'b1)
      $display("FAIL bp_halt state=%0d break=%b exp 0/1", run_state, break_hit); else n_pass++;
    repeat (3) @(posedge CLK);
    #1;
    n_total++; if (count !== 32'd100) $display("FAIL bp_count got %0d exp 100", count); else n_pass++;
  endtask

  task automatic test_skip();
    send_cmd(3'd1, 32'd0);
    n_total++; if (run_state !== 2'd1 || break_hit !== 1'b0 || ctr_enable !== 1'b1)
      $display("FAIL skip_start state=%0d break=%b en=%b exp 1/0/1", run_state, break_hit, ctr_enable); else n_pass++;
    repeat (3) @(posedge CLK);
    send_cmd(3'd2, 32'd0);
    n_total++; if (count !== 32'd104 || run_state !== 2'd0)
      $display("FAIL skip_past count=%0d state=%0d exp 104/0", count, run_state); else n_pass++;
    send_cmd(3'd6, 32'd0);
  endtask

  task automatic test_step();
    int s0;
    do_clear();
    s0 = step_pulses;
    send_cmd(3'd3, 32'd5);
    wait_halted(20, "step5");
    n_total++; if (step_pulses - s0 !== 5 || count !== 32'd5)
      $display("FAIL step5 pulses=%0d count=%0d exp 5/5", step_pulses - s0, count); else n_pass++;
    s0 = step_pulses;
    send_cmd(3'd3, 32'd0);
    wait_halted(20, "step0");
    n_total++; if (step_pulses - s0 !== 1 || count !== 32'd6)
      $display("FAIL step0 pulses=%0d count=%0d exp 1/6", step_pulses - s0, count); else n_pass++;
  endtask

  task automatic test_step_bp_clear();
    do_clear();
    send_cmd(3'd5, 32'd20);
    send_cmd(3'd3, 32'd50);
    wait_halted(100, "step_bp");
    n_total++; if (count !== 32'd20 || break_hit !== 1'b1)
      $display("FAIL step_bp count=%0d break=%b exp 20/1", count, break_hit); else n_pass++;
    repeat (3) @(posedge CLK);
    #1;
    n_total++; if (ctr_step !== 1'b0 || count !== 32'd20)
      $display("FAIL step_bp_discard step=%b count=%0d exp 0/20", ctr_step, count); else n_pass++;
    send_cmd(3'd4, 32'd0);
    n_total++; if (cmd_ready !== 1'b0 || ctr_reset !== 1'b1 || run_state !== 2'd3 || break_hit !== 1'b0)
      $display("FAIL clear_cycle ready=%b rst=%b state=%0d break=%b exp 0/1/3/0",
               cmd_ready, ctr_reset, run_state, break_hit); else n_pass++;
    @(posedge CLK);
    #1;
    n_total++; if (count !== 32'd0 || run_state !== 2'd0 || cmd_ready !== 1'b1 || ctr_reset !== 1'b0)
      $display("FAIL clear_done count=%0d state=%0d ready=%b rst=%b exp 0/0/1/0",
               count, run_state, cmd_ready, ctr_reset); else n_pass++;
    send_cmd(3'd6, 32'd0);
  endtask

  task automatic test_halt_bp_tie();
    do_clear();
    send_cmd(3'd5, 32'd10);
    send_cmd(3'd1, 32'd0);
    repeat (10) @(posedge CLK);
    send_cmd(3'd2, 32'd0);
    n_total++; if (run_state !== 2'd0 || break_hit !== 1'b1 || count !== 32'd10)
      $display("FAIL tie state=%0d break=%b count=%0d exp 0/1/10", run_state, break_hit, count); else n_pass++;
    send_cmd(3'd6, 32'd0);
  endtask

  task automatic test_errors();
    send_cmd(3'd1, 32'd0);
    send_cmd(3'd1, 32'd0);
    n_total++; if (cmd_err !== 1'b1 || run_state !== 2'd1)
      $display("FAIL err_run err=%b state=%0d exp 1/1", cmd_err, run_state); else n_pass++;
    @(posedge CLK);
    #1;
    n_total++; if (cmd_err !== 1'b0) $display("FAIL err_pulse got %b exp 0", cmd_err); else n_pass++;
    send_cmd(3'd3, 32'd4);
    n_total++; if (cmd_err !== 1'b1 || run_state !== 2'd1)
      $display("FAIL err_step err=%b state=%0d exp 1/1", cmd_err, run_state); else n_pass++;
    send_cmd(3'd7, 32'd1);
    n_total++; if (ctr_fast !== 1'b1 || cmd_err !== 1'b0)
      $display("FAIL set_fast fast=%b err=%b exp 1/0", ctr_fast, cmd_err); else n_pass++;
  endtask

  task automatic test_mid_reset();
    send_cmd(3'd5, 32'd3);
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    n_total++; if (ctr_reset !== 1'b1) $display("FAIL mid_rst_ctr_reset got %b exp 1", ctr_reset); else n_pass++;
    reset = 1'b0;
    n_total++; if (run_state !== 2'd0 || ctr_fast !== 1'b0 || ctr_enable !== 1'b0 || count !== 32'd0)
      $display("FAIL mid_rst state=%0d fast=%b en=%b count=%0d exp 0/0/0/0",
               run_state, ctr_fast, ctr_enable, count); else n_pass++;
    send_cmd(3'd1, 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    n_total++; if (run_state !== 2'd1 || count !== 32'd10)
      $display("FAIL mid_rst_bp_off state=%0d count=%0d exp 1/10", run_state, count); else n_pass++;
    send_cmd(3'd2, 32'd0);
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_breakpoint();
    test_skip();
    test_step();
    test_step_bp_clear();
    test_halt_bp_tie();
    test_errors();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
